// File: rtl/audio_tdm_tx_if.sv
// Valid/ready bundle carrying one parallel audio frame (CHANNELS samples of WIDTH bits)
// into audio_tdm_tx; channel k occupies in_data[k*WIDTH +: WIDTH].
interface audio_tdm_tx_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 24
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/audio_tdm_tx.sv
// I2S/left-justified/TDM serial audio transmitter; AUDIO_TX_UNDERRUN_MUTE_EN selects mute (else repeat) on underrun.
// Latency: sample MSB on sdata the clk after the load fall event; frame period 2*DIV*CHANNELS*SLOT clks.
// Backpressure: one-frame holding buffer, in_ready low while full; an empty buffer at load raises underrun.
module audio_tdm_tx #(
    parameter int WIDTH    = 24,
    parameter int SLOT     = 24,
    parameter int CHANNELS = 2,
    parameter int DIV      = 4,
    parameter int DELAY    = 0
) (
    input  logic          clk,
    input  logic          rst,
    audio_tdm_tx_if.slave in_if,
    output logic          bclk,
    output logic          lrclk,
    output logic          sdata,
    output logic          frame_start,
    output logic          underrun
);
    localparam int FRAME_BITS = CHANNELS * SLOT;
    localparam int DATA_W     = CHANNELS * WIDTH;
    localparam int DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    logic [DIV_W-1:0]      div_q, div_d;
    logic                  bclk_q, bclk_d;
    logic                  lrclk_q, lrclk_d;
    logic [BIT_W-1:0]      b_q, b_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [DATA_W-1:0]     buf_q, buf_d;
    logic                  buf_vld_q, buf_vld_d;
    logic                  live_q, live_d;
    logic                  frame_start_q, frame_start_d;
    logic                  underrun_q, underrun_d;

    logic                  wrap;
    logic                  fall;
    logic                  load;
    logic                  hs;
    logic [BIT_W-1:0]      b_next;
    logic [DATA_W-1:0]     fill_dat;

    // Slot 0 sits at the shifter MSB end so it is sent first; each sample is left-aligned in its slot.
    function automatic logic [FRAME_BITS-1:0] frame_fmt(input logic [DATA_W-1:0] d);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            f[FRAME_BITS-1-k*SLOT -: WIDTH] = d[k*WIDTH +: WIDTH];
        end
        return f;
    endfunction

    assign wrap   = (div_q == DIV_W'(DIV - 1));
    assign fall   = wrap & bclk_q;
    assign b_next = (b_q == BIT_W'(FRAME_BITS - 1)) ? '0 : b_q + 1'b1;
    assign load   = fall & (b_next == BIT_W'(DELAY));

    // live_q keeps in_ready low through reset and for the release cycle.
    assign in_if.in_ready = live_q & ~buf_vld_q;
    assign hs             = in_if.in_valid & in_if.in_ready;

`ifdef AUDIO_TX_UNDERRUN_MUTE_EN
    assign fill_dat = buf_vld_q ? buf_q : '0;
`else
    logic [DATA_W-1:0] last_q, last_d;

    assign fill_dat = buf_vld_q ? buf_q : last_q;

    always_comb begin
        last_d = last_q;
        if (load && buf_vld_q) begin
            last_d = buf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        div_d         = wrap ? '0 : div_q + 1'b1;
        bclk_d        = wrap ? ~bclk_q : bclk_q;
        b_d           = b_q;
        lrclk_d       = lrclk_q;
        shift_d       = shift_q;
        buf_d         = buf_q;
        buf_vld_d     = buf_vld_q;
        live_d        = 1'b1;
        frame_start_d = load;
        underrun_d    = load & ~buf_vld_q;

        if (fall) begin
            b_d = b_next;
            if (CHANNELS == 2) begin
                lrclk_d = (b_next >= BIT_W'(SLOT));
            end else begin
                lrclk_d = (b_next == '0);
            end
        end

        if (load) begin
            shift_d = frame_fmt(fill_dat);
        end else if (fall) begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
        end

        // Load consumes the pre-cycle buffer; a same-cycle handshake refills it for the next frame.
        if (load) begin
            buf_vld_d = 1'b0;
        end
        if (hs) begin
            buf_vld_d = 1'b1;
            buf_d     = in_if.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            b_q           <= BIT_W'(FRAME_BITS - 1);
            shift_q       <= '0;
            buf_q         <= '0;
            buf_vld_q     <= 1'b0;
            live_q        <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            div_q         <= div_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            b_q           <= b_d;
            shift_q       <= shift_d;
            buf_q         <= buf_d;
            buf_vld_q     <= buf_vld_d;
            live_q        <= live_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign sdata       = shift_q[FRAME_BITS-1];
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
endmodule
